sdi_raster_sequencer: RTL

- Generates the 10-bit single-link SDI word stream (interleaved C/Y, progressive raster) for the SDI serializer parallel port on the Mini PCIe header.
- Owns the raster timing: horizontal/vertical counters, EAV/SAV insertion with XYZ protection bits, and start/stop sequencing on frame boundaries.
- Pulls active-picture words from an upstream pixel source over a valid/ready handshake and substitutes black on underrun.
- Sits between the pixel source and the serializer data pins, clocked by the serializer PCLK domain.

---
 rtl/sdi_pkg.sv | 34 +++
 rtl/sdi_raster_counter.sv | 53 +++++
 rtl/sdi_raster_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sdi_pkg.sv
// Shared constants, state encoding and the TRS protection-word helper for the
// SDI raster sequencer.
package sdi_pkg;

    // Default raster geometry (1080p, interleaved C/Y words)
    localparam int DEF_WORDS_PER_LINE  = 4400;
    localparam int DEF_ACTIVE_WORDS    = 3840;
    localparam int DEF_LINES_PER_FRAME = 1125;
    localparam int DEF_ACTIVE_LINES    = 1080;

    // Widths derived from the default geometry; the line number port is sized by LINE_W
    localparam int WORD_W = $clog2(DEF_WORDS_PER_LINE);
    localparam int LINE_W = $clog2(DEF_LINES_PER_FRAME);

    // Timing reference sequence preamble words
    localparam logic [9:0] TRS_ONE  = 10'h3FF;
    localparam logic [9:0] TRS_ZERO = 10'h000;

    // Blanking levels for chroma (even word) and luma (odd word)
    localparam logic [9:0] BLANK_C = 10'h200;
    localparam logic [9:0] BLANK_Y = 10'h040;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } seqState_t;

    // XYZ word with Hamming-style protection bits; two LSBs are always zero
    function automatic logic [9:0] sdi_xyz(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h, 2'b00};
    endfunction

endpackage

// File: rtl/sdi_raster_counter.sv
// Horizontal/vertical raster position with region decode. Held at zero while
// cleared, steps one word per cycle while advancing.
module sdi_raster_counter
    import sdi_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int ACTIVE_WORDS    = DEF_ACTIVE_WORDS,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    localparam int HW = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              clear,
    input  logic              advance,
    output logic [HW-1:0]     h,
    output logic [LINE_W-1:0] v,
    output logic              endOfLine,
    output logic              endOfFrame,
    output logic              activeLine,
    output logic              activeWord
);

    localparam logic [HW-1:0]     H_LAST       = HW'(WORDS_PER_LINE - 1);
    localparam logic [HW-1:0]     H_ACT_FIRST  = HW'(WORDS_PER_LINE - ACTIVE_WORDS);
    localparam logic [LINE_W-1:0] V_LAST       = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [LINE_W-1:0] V_ACT_END    = LINE_W'(ACTIVE_LINES);

    // endOfFrame marks the final line; combined with endOfLine it is the last word
    assign endOfLine  = (h == H_LAST);
    assign endOfFrame = (v == V_LAST);
    assign activeLine = (v < V_ACT_END);
    assign activeWord = (h >= H_ACT_FIRST);

    // Word counter wraps per line, line counter wraps per frame
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            h <= '0;
            v <= '0;
        end else if (clear) begin
            h <= '0;
            v <= '0;
        end else if (advance) begin
            if (endOfLine) begin
                h <= '0;
                v <= endOfFrame ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdi_raster_sequencer.sv
// SDI word-stream generator: raster timing, EAV/SAV insertion, active-picture
// pull with black substitution on underrun, frame-aligned start/stop.
module sdi_raster_sequencer
    import sdi_pkg::*;
#(
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int ACTIVE_WORDS    = DEF_ACTIVE_WORDS,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES
) (
    input  logic        iCLK,
    input  logic        iRESETn,
    input  logic        iENABLE,
    input  logic        iLOCKED,
    input  logic        iCLR_STATUS,
    input  logic [9:0]  iPIX_DATA,
    input  logic        iPIX_VALID,
    output logic        oPIX_READY,
    output logic [9:0]  oDATA,
    output logic        oSOF,
    output logic [10:0] oLINE,
    output logic        oRUNNING,
    output logic        oLOCKED,
    output logic        oUNDERRUN,
    output logic [15:0] oUNDERRUN_CNT,
    output logic        oLOCK_LOSS
);

    localparam int            HW      = $clog2(WORDS_PER_LINE);
    localparam logic [HW-1:0] SAV_H   = HW'(WORDS_PER_LINE - ACTIVE_WORDS - 8);
    localparam logic [HW-1:0] TRS_LEN = HW'(8);

    seqState_t         state, nextState;
    logic [HW-1:0]     h, savOff;
    logic [LINE_W-1:0] v;
    logic              endOfLine, endOfFrame, activeLine, activeWord;
    logic              running, underrun, inEav, inSav;
    logic [2:0]        trsIdx;
    logic [9:0]        word;
    logic              lockMeta, lockSync;

    assign running    = (state != ST_IDLE);
    assign oRUNNING   = running;
    // The raster never stalls: a ready word is consumed whether or not it is valid
    assign oPIX_READY = running && activeLine && activeWord;
    assign underrun   = oPIX_READY && !iPIX_VALID;
    assign oLOCKED    = lockSync;

    sdi_raster_counter #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ACTIVE_WORDS   (ACTIVE_WORDS),
        .LINES_PER_FRAME(LINES_PER_FRAME),
        .ACTIVE_LINES   (ACTIVE_LINES)
    ) uCounter (
        .clk       (iCLK),
        .rstN      (iRESETn),
        .clear     (!running),
        .advance   (running),
        .h         (h),
        .v         (v),
        .endOfLine (endOfLine),
        .endOfFrame(endOfFrame),
        .activeLine(activeLine),
        .activeWord(activeWord)
    );

    // State register
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) state <= ST_IDLE;
        else          state <= nextState;
    end

    // Next state: stop only after the last word of the frame has been emitted
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:     if (iENABLE) nextState = ST_RUN;
            ST_RUN:      if (!iENABLE) nextState = ST_STOPPING;
            ST_STOPPING: begin
                if (iENABLE)                       nextState = ST_RUN;
                else if (endOfLine && endOfFrame)  nextState = ST_IDLE;
            end
            default:     nextState = ST_IDLE;
        endcase
    end

    // Word map: TRS preambles, XYZ, active picture, else blanking by parity
    always_comb begin
        savOff = h - SAV_H;
        inEav  = (h < TRS_LEN);
        inSav  = (h >= SAV_H) && (savOff < TRS_LEN);
        trsIdx = inEav ? h[2:0] : savOff[2:0];
        word   = h[0] ? BLANK_Y : BLANK_C;
        if (inEav || inSav) begin
            case (trsIdx)
                3'd0, 3'd1: word = TRS_ONE;
                3'd6, 3'd7: word = sdi_xyz(1'b0, !activeLine, inEav);
                default:    word = TRS_ZERO;
            endcase
        end else if (oPIX_READY && iPIX_VALID) begin
            word = iPIX_DATA;
        end
    end

    // Registered serializer outputs, one cycle behind the raster position
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oDATA <= BLANK_C;
            oSOF  <= 1'b0;
            oLINE <= '0;
        end else if (running) begin
            oDATA <= word;
            oSOF  <= (h == '0) && (v == '0);
            oLINE <= v;
        end else begin
            oDATA <= BLANK_C;
            oSOF  <= 1'b0;
            oLINE <= '0;
        end
    end

    // Two-flop synchronizer for the serializer lock indication
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            lockMeta <= 1'b0;
            lockSync <= 1'b0;
        end else begin
            lockMeta <= iLOCKED;
            lockSync <= lockMeta;
        end
    end

    // Sticky status; a set event in the same cycle as a clear takes priority
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oUNDERRUN     <= 1'b0;
            oUNDERRUN_CNT <= '0;
            oLOCK_LOSS    <= 1'b0;
        end else begin
            if (underrun)         oUNDERRUN <= 1'b1;
            else if (iCLR_STATUS) oUNDERRUN <= 1'b0;

            if (underrun) begin
                if (iCLR_STATUS)                   oUNDERRUN_CNT <= 16'd1;
                else if (oUNDERRUN_CNT != 16'hFFFF) oUNDERRUN_CNT <= oUNDERRUN_CNT + 16'd1;
            end else if (iCLR_STATUS) begin
                oUNDERRUN_CNT <= '0;
            end

            // lockSync falls on this edge exactly when lockMeta is already low
            if (lockSync && !lockMeta && running) oLOCK_LOSS <= 1'b1;
            else if (iCLR_STATUS)                 oLOCK_LOSS <= 1'b0;
        end
    end

endmodule
